// File: rtl/vx_mem_ahb_bridge.sv
// Vortex memory port to AHB manager bridge: splits one cache-line request into
// single BUS_WIDTH transfers and reassembles read beats into a tagged line.
module vx_mem_ahb_bridge #(
    parameter int          DATA_WIDTH = 512,
    parameter int          BUS_WIDTH  = 32,
    parameter int          ADDR_WIDTH = 26,
    parameter int          TAG_WIDTH  = 56,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    nRST,
    input  logic                    mem_req_valid,
    output logic                    mem_req_ready,
    input  logic                    mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_rsp_valid,
    input  logic                    mem_rsp_ready,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    output logic [31:0]             HADDR,
    output logic [1:0]              HTRANS,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [BUS_WIDTH-1:0]    HWDATA,
    output logic [BUS_WIDTH/8-1:0]  HWSTRB,
    input  logic [BUS_WIDTH-1:0]    HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP,
    output logic                    err,
    input  logic                    err_clear
);

    localparam int         BEATS      = DATA_WIDTH / BUS_WIDTH;
    localparam int         BUS_BYTES  = BUS_WIDTH / 8;
    localparam int         LINE_BYTES = DATA_WIDTH / 8;
    localparam int         BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [2:0] SIZE       = 3'($clog2(BUS_BYTES));
    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DRAIN, S_RSP} state_e;

    state_e                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH/8-1:0] byteen_q, byteen_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [BEATS-1:0]        mask_q, mask_d;
    logic [BEAT_W-1:0]       aph_beat_q, aph_beat_d;
    logic [BEAT_W-1:0]       dph_beat_q, dph_beat_d;
    logic                    dph_valid_q, dph_valid_d;
    logic                    abort_q, abort_d;
    logic                    err_q, err_d;
    logic [1:0]              htrans_q, htrans_d;
    logic [31:0]             haddr_q, haddr_d;
    logic                    hwrite_q, hwrite_d;
    logic [BUS_WIDTH-1:0]    hwdata_q, hwdata_d;
    logic [BUS_BYTES-1:0]    hwstrb_q, hwstrb_d;

    logic [BEATS-1:0]        active;
    logic [BEAT_W-1:0]       nxt;
    logic                    req_fire;
    logic                    dph_err;

    function automatic logic [31:0] beat_addr(input logic [ADDR_WIDTH-1:0] line_addr,
                                              input logic [BEAT_W-1:0]     beat);
        logic [31:0] line_off;
        line_off = 32'(line_addr) * 32'(LINE_BYTES);
        return BASE_ADDR + line_off + 32'(beat) * 32'(BUS_BYTES);
    endfunction

    function automatic logic [BEAT_W-1:0] first_beat(input logic [BEATS-1:0] mask);
        logic [BEAT_W-1:0] idx;
        idx = '0;
        for (int b = BEATS - 1; b >= 0; b--) begin
            if (mask[b]) idx = BEAT_W'(b);
        end
        return idx;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        byteen_d    = byteen_q;
        tag_d       = tag_q;
        rsp_data_d  = rsp_data_q;
        mask_d      = mask_q;
        aph_beat_d  = aph_beat_q;
        dph_beat_d  = dph_beat_q;
        dph_valid_d = dph_valid_q;
        abort_d     = abort_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        hwstrb_d    = hwstrb_q;
        nxt         = '0;

        req_fire = mem_req_valid & ready_q;
        // First cycle of a two-cycle AHB error response on an open data phase.
        dph_err  = dph_valid_q & HRESP & ~HREADY;

        for (int b = 0; b < BEATS; b++) begin
            active[b] = ~mem_req_rw | (|mem_req_byteen[b*BUS_BYTES +: BUS_BYTES]);
        end

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    rw_d       = mem_req_rw;
                    addr_d     = mem_req_addr;
                    data_d     = mem_req_data;
                    byteen_d   = mem_req_byteen;
                    tag_d      = mem_req_tag;
                    rsp_data_d = '0;
                    if (|active) begin
                        nxt        = first_beat(active);
                        aph_beat_d = nxt;
                        mask_d     = active & ~(BEATS'(1) << nxt);
                        htrans_d   = TR_NONSEQ;
                        haddr_d    = beat_addr(mem_req_addr, nxt);
                        hwrite_d   = mem_req_rw;
                        state_d    = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (dph_err) begin
                    htrans_d = TR_IDLE;
                    mask_d   = '0;
                    abort_d  = 1'b1;
                    state_d  = S_DRAIN;
                end else if (HREADY) begin
                    if (dph_valid_q && !rw_q) begin
                        rsp_data_d[dph_beat_q*BUS_WIDTH +: BUS_WIDTH] = HRDATA;
                    end
                    dph_valid_d = 1'b1;
                    dph_beat_d  = aph_beat_q;
                    hwdata_d    = data_q[aph_beat_q*BUS_WIDTH +: BUS_WIDTH];
                    hwstrb_d    = byteen_q[aph_beat_q*BUS_BYTES +: BUS_BYTES];
                    if (|mask_q) begin
                        nxt        = first_beat(mask_q);
                        aph_beat_d = nxt;
                        mask_d     = mask_q & ~(BEATS'(1) << nxt);
                        haddr_d    = beat_addr(addr_q, nxt);
                    end else begin
                        htrans_d = TR_IDLE;
                        state_d  = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (dph_err) begin
                    abort_d = 1'b1;
                end else if (HREADY) begin
                    if (!rw_q && !abort_q) begin
                        rsp_data_d[dph_beat_q*BUS_WIDTH +: BUS_WIDTH] = HRDATA;
                    end
                    dph_valid_d = 1'b0;
                    abort_d     = 1'b0;
                    state_d     = rw_q ? S_IDLE : S_RSP;
                end
            end
            S_RSP: begin
                if (mem_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RSP);
        // A new error outranks a simultaneous clear.
        err_d       = dph_err | (err_q & ~err_clear);
    end

    // NOTE: the line and response buffers are reset with everything else so a reset mid-transfer leaves no stale data on the outputs.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            byteen_q    <= '0;
            tag_q       <= '0;
            rsp_data_q  <= '0;
            mask_q      <= '0;
            aph_beat_q  <= '0;
            dph_beat_q  <= '0;
            dph_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
            htrans_q    <= TR_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            hwstrb_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d input.
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            byteen_q    <= byteen_d;
            tag_q       <= tag_d;
            rsp_data_q  <= rsp_data_d;
            mask_q      <= mask_d;
            aph_beat_q  <= aph_beat_d;
            dph_beat_q  <= dph_beat_d;
            dph_valid_q <= dph_valid_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            hwstrb_q    <= hwstrb_d;
        end
    end

    assign mem_req_ready = ready_q;
    assign mem_rsp_valid = rsp_valid_q;
    assign mem_rsp_data  = rsp_data_q;
    assign mem_rsp_tag   = tag_q;
    assign HADDR         = haddr_q;
    assign HTRANS        = htrans_q;
    assign HWRITE        = hwrite_q;
    assign HSIZE         = SIZE;
    assign HBURST        = 3'b000;
    assign HWDATA        = hwdata_q;
    assign HWSTRB        = hwstrb_q;
    assign err           = err_q;

endmodule

// File: doc/vx_mem_ahb_bridge.md
# vx_mem_ahb_bridge

Parametrised bridge from the Vortex GPU memory request/response port to a single AHB manager port. It serialises one Vortex cache-line request into BUS_WIDTH-wide single transfers, skipping write beats whose byte enables are all zero, and reassembles read beats into a full line returned with the original tag. It sits between Vortex and the SoC AHB fabric, beside the memory-slave and control/status subordinates in the Vortex wrapper, replacing a fixed-width, blocking path.

## Interface
- DATA_WIDTH, 512, Vortex line width in bits; integer multiple of BUS_WIDTH
- BUS_WIDTH, 32, AHB data width in bits; 32 or 64
- ADDR_WIDTH, 26, Vortex line address width
- TAG_WIDTH, 56, Vortex request/response tag width
- BASE_ADDR, 32'h0000_0000, AHB byte address of Vortex line 0
- Derived values: BEATS = DATA_WIDTH/BUS_WIDTH, a power of two; BUS_BYTES = BUS_WIDTH/8

Ports:
- clk  in  1  single clock
- nRST  in  1  asynchronous, active-low reset
- mem_req_valid / mem_req_ready  in / out  1  request handshake
- mem_req_rw  in  1  1 = write
- mem_req_byteen  in  DATA_WIDTH/8  line byte enables
- mem_req_addr  in  ADDR_WIDTH  line address
- mem_req_data  in  DATA_WIDTH  write line
- mem_req_tag  in  TAG_WIDTH  request tag
- mem_rsp_valid / mem_rsp_ready  out / in  1  read response handshake
- mem_rsp_data  out  DATA_WIDTH  read line
- mem_rsp_tag  out  TAG_WIDTH  tag of the request being answered
- HADDR  out  32; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3 (always SINGLE)
- HWDATA  out  BUS_WIDTH; HWSTRB  out  BUS_BYTES
- HRDATA  in  BUS_WIDTH; HREADY  in  1; HRESP  in  1
- err  out  1  sticky bus-error flag
- err_clear  in  1  clears err

## Operation
- States: IDLE, BUS, DRAIN, RSP.
- IDLE
  - mem_req_ready = 1.
  - On handshake, latch rw, addr, data, byteen and tag; compute a mask of active beats.
  - Reads: all beats are active. Writes: a beat is active when its byteen slice is nonzero.
  - No active beats: stay in IDLE with no bus traffic.
  - Otherwise go to BUS.
- BUS
  - Drives one NONSEQ address phase per active beat, in ascending beat order.
  - HADDR = BASE_ADDR + addr*(DATA_WIDTH/8) + beat*BUS_BYTES, truncated to 32 bits.
  - HSIZE = log2(BUS_BYTES); HWRITE = rw.
  - The address phase of the next beat overlaps the data phase of the current beat.
  - After the last address phase is accepted, go to DRAIN.
- Data phase
  - HWDATA = data[beat*BUS_WIDTH +: BUS_WIDTH]; HWSTRB = byteen slice for that beat.
  - Reads capture HRDATA into rsp_data[beat*BUS_WIDTH +: BUS_WIDTH] when HREADY = 1.
  - HWDATA and HWSTRB are held stable while HREADY = 0.
- DRAIN: the last data phase completes on HREADY = 1. Reads go to RSP; writes go to IDLE. Writes produce no Vortex response.
- RSP
  - mem_rsp_valid = 1; data and tag are held stable until mem_rsp_ready.
  - Go to IDLE on the handshake.
  - No new request is accepted while in RSP.
- HTRANS = IDLE whenever no address phase is pending.
- Error response (first cycle: HRESP = 1, HREADY = 0)
  - Drive HTRANS = IDLE on the next cycle, cancelling the pending address phase; set err.
  - Abort the remaining beats. Reads still go to RSP, with beats not captured returned as zero. Writes go to IDLE.
- err_clear clears err. If err_clear and a new error occur in the same cycle, the set wins.

## Timing
- Reset values: mem_req_ready = 0 while nRST is low, then 1 in IDLE; mem_rsp_valid = 0, mem_rsp_data = 0, mem_rsp_tag = 0; HTRANS = IDLE, HADDR = 0, HWRITE = 0, HWDATA = 0, HWSTRB = 0, HSIZE = log2(BUS_BYTES); err = 0.
- Request handshake in cycle 0 with HREADY held at 1:
  - First address phase in cycle 1.
  - Last address phase in cycle N, where N = number of active beats.
  - Last data phase in cycle N+1.
  - Read: mem_rsp_valid in cycle N+2. Write: mem_req_ready = 1 in cycle N+2.
- Each cycle of HREADY = 0 stretches the current phase by one cycle.
- Reset asserted mid-transfer: outputs return to reset values asynchronously, the partial line is discarded and no response is issued.

## Test plan
- Default parameters, read at addr 0x10, tag 0x5A, HREADY = 1:
  - HADDR runs 0x400, 0x404, …, 0x43C with NONSEQ in cycles 1–16.
  - mem_rsp_valid in cycle 18 with the 16 HRDATA words packed in order and tag 0x5A.
- Write with byteen set only for beats 3 and 9 (0xF each):
  - Exactly two transfers, HADDR = line base + 0x0C and + 0x24, with the matching HWDATA and HWSTRB = 0xF.
  - mem_req_ready returns in cycle 4; no response is issued.
- Write with all-zero byteen: no HTRANS activity, and mem_req_ready stays 1 the next cycle.
- HREADY low for 3 cycles on beat 5 of a read: HADDR/HWDATA stable, and the response arrives 3 cycles later with correct data.
- HRESP two-cycle error on beat 2 of a read:
  - HTRANS = IDLE on the cycle after the first error cycle; err = 1.
  - Response has beats 0–1 valid and beats 2–15 zero.
  - err_clear then drops err.
- BUS_WIDTH = 64, DATA_WIDTH = 256: 4 beats, HSIZE = 3, HADDR stride 8. nRST pulsed at beat 2: HTRANS = IDLE immediately and no mem_rsp_valid afterwards.
